// File: rtl/pipe_control_unit_if.sv
// Handshake and control bus between the instruction source and pipe_control_unit.
// master drives instruction/memory status, slave (the control unit) drives control strobes.
interface pipe_control_unit_if #(
    parameter int OPCODE_W = 9,
    parameter int ALU_FN_W = 3
);
    logic                instr_valid;
    logic [OPCODE_W-1:0] opcode;
    logic                instr_ready;
    logic                stall_in;
    logic                flush;
    logic                mem_ready;
    logic                mem_en;
    logic                rw;
    logic                data_read;
    logic                data_write;
    logic [ALU_FN_W-1:0] alu_function;
    logic                ctrl_valid;
    logic                busy;
    logic                mem_timeout;
    logic                illegal;

    modport master (
        output instr_valid, opcode, stall_in, flush, mem_ready,
        input  instr_ready, mem_en, rw, data_read, data_write,
               alu_function, ctrl_valid, busy, mem_timeout, illegal
    );

    modport slave (
        input  instr_valid, opcode, stall_in, flush, mem_ready,
        output instr_ready, mem_en, rw, data_read, data_write,
               alu_function, ctrl_valid, busy, mem_timeout, illegal
    );
endinterface

// File: rtl/pipe_control_unit.sv
// Single-issue pipeline control unit: decodes opcodes into registered strobes and waits on memory.
// Optional macro CU_ILLEGAL_TRAP_EN traps unrecognised opcodes in TRAP until flush/reset.
module pipe_control_unit #(
    parameter int OPCODE_W    = 9,
    parameter int ALU_FN_W    = 3,
    parameter int MEM_TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipe_control_unit_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        MEM_WAIT = 2'd2,
        TRAP     = 2'd3
    } state_t;

    typedef struct packed {
        logic                mem_en;
        logic                rw;
        logic                data_read;
        logic                data_write;
        logic [ALU_FN_W-1:0] fn;
        logic                ctrl_valid;
    } ctrl_t;

    localparam logic [OPCODE_W-1:0] OP_LOAD  = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_STORE = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_ADD   = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_NOT   = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_NOP   = OPCODE_W'(5);
    localparam logic [7:0]          CNT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state_q;
    logic [7:0] cnt_q;
    ctrl_t      ctrl_q;
    logic       mem_timeout_q;
    ctrl_t      ctrl_d;
    logic       mem_op_d;
    logic       accept;
`ifdef CU_ILLEGAL_TRAP_EN
    logic       known_d;
    logic       illegal_q;
`endif

    always_comb begin
        ctrl_d            = '0;
        ctrl_d.ctrl_valid = 1'b1;
        mem_op_d          = 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
        known_d           = 1'b1;
`endif
        case (bus.opcode)
            OP_LOAD: begin
                ctrl_d.mem_en     = 1'b1;
                ctrl_d.rw         = 1'b1;
                ctrl_d.data_write = 1'b1;
                ctrl_d.fn         = ALU_FN_W'(2'b00);
                mem_op_d          = 1'b1;
            end
            OP_STORE: begin
                ctrl_d.mem_en    = 1'b1;
                ctrl_d.data_read = 1'b1;
                ctrl_d.fn        = ALU_FN_W'(2'b10);
                mem_op_d         = 1'b1;
            end
            OP_ADD: begin
                ctrl_d.data_read  = 1'b1;
                ctrl_d.data_write = 1'b1;
                ctrl_d.fn         = ALU_FN_W'(2'b11);
            end
            OP_NOT: begin
                ctrl_d.data_read  = 1'b1;
                ctrl_d.data_write = 1'b1;
                ctrl_d.fn         = ALU_FN_W'(2'b01);
            end
            OP_NOP: begin
            end
            default: begin
`ifdef CU_ILLEGAL_TRAP_EN
                known_d = 1'b0;
`endif
            end
        endcase
    end

    assign bus.instr_ready = rst_n && (state_q == IDLE || state_q == ISSUE)
                             && !bus.stall_in && !bus.flush;
    assign accept          = bus.instr_valid && bus.instr_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            ctrl_q        <= '0;
            mem_timeout_q <= 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
            illegal_q     <= 1'b0;
`endif
        end else begin
            mem_timeout_q <= 1'b0;
            if (bus.flush) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                ctrl_q    <= '0;
`ifdef CU_ILLEGAL_TRAP_EN
                illegal_q <= 1'b0;
`endif
            end else begin
                case (state_q)
                    MEM_WAIT: begin
                        // Completion and timeout are evaluated regardless of stall_in.
                        if (bus.mem_ready || cnt_q == CNT_LAST) begin
                            state_q       <= IDLE;
                            cnt_q         <= '0;
                            ctrl_q        <= '0;
                            mem_timeout_q <= !bus.mem_ready;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                    TRAP: begin
                    end
                    default: begin
                        if (!bus.stall_in) begin
                            if (accept) begin
`ifdef CU_ILLEGAL_TRAP_EN
                                if (!known_d) begin
                                    ctrl_q    <= '0;
                                    illegal_q <= 1'b1;
                                    state_q   <= TRAP;
                                end else
`endif
                                begin
                                    ctrl_q  <= ctrl_d;
                                    cnt_q   <= '0;
                                    state_q <= mem_op_d ? MEM_WAIT : ISSUE;
                                end
                            end else begin
                                ctrl_q  <= '0;
                                state_q <= IDLE;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign bus.mem_en       = ctrl_q.mem_en;
    assign bus.rw           = ctrl_q.rw;
    assign bus.data_read    = ctrl_q.data_read;
    assign bus.data_write   = ctrl_q.data_write;
    assign bus.alu_function = ctrl_q.fn;
    assign bus.ctrl_valid   = ctrl_q.ctrl_valid;
    assign bus.busy         = (state_q == MEM_WAIT) || (state_q == TRAP);
    assign bus.mem_timeout  = mem_timeout_q;
`ifdef CU_ILLEGAL_TRAP_EN
    assign bus.illegal      = illegal_q;
`else
    assign bus.illegal      = 1'b0;
`endif
endmodule
